// File: rtl/ext_obi_req_buffer.sv
// Request decoupling buffer between a CPU OBI master port and the system bus.
// CPU requests are queued in a small FIFO and forwarded to the bus. A credit
// count limits how many requests can be accepted but not yet answered.
// Responses go straight back to the CPU in request order. A bus rvalid that
// arrives with nothing in flight is dropped and flagged on a sticky error bit.
module ext_obi_req_buffer #(
    parameter int unsigned DEPTH           = 2,  // legal range 1..4
    parameter int unsigned MAX_OUTSTANDING = 2   // legal range DEPTH..7
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    // CPU request
    input  logic        cpu_req_req_i,
    input  logic        cpu_req_we_i,
    input  logic [3:0]  cpu_req_be_i,
    input  logic [31:0] cpu_req_addr_i,
    input  logic [31:0] cpu_req_wdata_i,

    // CPU response
    output logic        cpu_resp_gnt_o,
    output logic        cpu_resp_rvalid_o,
    output logic [31:0] cpu_resp_rdata_o,

    // Bus request
    output logic        bus_req_req_o,
    output logic        bus_req_we_o,
    output logic [3:0]  bus_req_be_o,
    output logic [31:0] bus_req_addr_o,
    output logic [31:0] bus_req_wdata_o,

    // Bus response
    input  logic        bus_resp_gnt_i,
    input  logic        bus_resp_rvalid_i,
    input  logic [31:0] bus_resp_rdata_i,

    output logic [2:0]  outstanding_o,
    output logic        resp_err_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
    localparam logic [3:0]       MAX_C    = 4'(MAX_OUTSTANDING);

    // FIFO payload storage (no reset: contents are only meaningful via count)
    logic        we_q    [DEPTH];
    logic [3:0]  be_q    [DEPTH];
    logic [31:0] addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       inflight_q, inflight_d;
    logic             respErr_q, respErr_d;

    logic       notEmpty;
    logic       full;
    logic [3:0] outstandingSum;
    logic       creditAvail;
    logic       push;
    logic       pop;
    logic       rspAccept;
    logic       rspSpurious;

    // Grant depends only on registered state and the CPU request, so there is
    // no path from the bus response into the grant. Gating with rst_ni keeps
    // the grant low while reset is held.
    assign notEmpty       = (count_q != 3'd0);
    assign full           = (count_q == DEPTH_C);
    assign outstandingSum = {1'b0, count_q} + {1'b0, inflight_q};
    assign creditAvail    = (outstandingSum < MAX_C);
    assign push           = cpu_req_req_i & rst_ni & ~full & creditAvail;
    assign pop            = notEmpty & bus_resp_gnt_i;
    assign rspAccept      = bus_resp_rvalid_i & (inflight_q != 3'd0);
    assign rspSpurious    = bus_resp_rvalid_i & (inflight_q == 3'd0);

    assign cpu_resp_gnt_o    = push;
    assign cpu_resp_rvalid_o = rspAccept;
    assign cpu_resp_rdata_o  = bus_resp_rdata_i;

    // The head entry drives the bus; the bus sees zeros when the FIFO is empty.
    assign bus_req_req_o   = notEmpty;
    assign bus_req_we_o    = notEmpty ? we_q[rdPtr_q]    : 1'b0;
    assign bus_req_be_o    = notEmpty ? be_q[rdPtr_q]    : 4'h0;
    assign bus_req_addr_o  = notEmpty ? addr_q[rdPtr_q]  : 32'h0;
    assign bus_req_wdata_o = notEmpty ? wdata_q[rdPtr_q] : 32'h0;

    assign outstanding_o = outstandingSum[2:0];
    assign resp_err_o    = respErr_q;

    // Next-state for pointers (wrapping at DEPTH), FIFO count, in-flight count and error flag.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        respErr_d  = respErr_q | rspSpurious;

        if (push) begin
            wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        case ({pop, rspAccept})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Control state registers, all cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= 3'd0;
            inflight_q <= 3'd0;
            respErr_q  <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            respErr_q  <= respErr_d;
        end
    end

    // Write the accepted CPU request into the tail slot.
    always_ff @(posedge clk_i) begin
        if (push) begin
            we_q[wrPtr_q]    <= cpu_req_we_i;
            be_q[wrPtr_q]    <= cpu_req_be_i;
            addr_q[wrPtr_q]  <= cpu_req_addr_i;
            wdata_q[wrPtr_q] <= cpu_req_wdata_i;
        end
    end

endmodule

// File: tb/tb_ext_obi_req_buffer.sv
// Testbench for ext_obi_req_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the buffer.
module tb_ext_obi_req_buffer;

    localparam int DEPTH = 2;
    localparam int MAX_OUTSTANDING = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cpu_req_req_i = 1'b0;
    logic        cpu_req_we_i = 1'b0;
    logic [3:0]  cpu_req_be_i = 4'h0;
    logic [31:0] cpu_req_addr_i = 32'h0;
    logic [31:0] cpu_req_wdata_i = 32'h0;
    logic        cpu_resp_gnt_o;
    logic        cpu_resp_rvalid_o;
    logic [31:0] cpu_resp_rdata_o;
    logic        bus_req_req_o;
    logic        bus_req_we_o;
    logic [3:0]  bus_req_be_o;
    logic [31:0] bus_req_addr_o;
    logic [31:0] bus_req_wdata_o;
    logic        bus_resp_gnt_i = 1'b0;
    logic        bus_resp_rvalid_i = 1'b0;
    logic [31:0] bus_resp_rdata_i = 32'h0;
    logic [2:0]  outstanding_o;
    logic        resp_err_o;

    ext_obi_req_buffer #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .cpu_req_req_i(cpu_req_req_i),
        .cpu_req_we_i(cpu_req_we_i),
        .cpu_req_be_i(cpu_req_be_i),
        .cpu_req_addr_i(cpu_req_addr_i),
        .cpu_req_wdata_i(cpu_req_wdata_i),
        .cpu_resp_gnt_o(cpu_resp_gnt_o),
        .cpu_resp_rvalid_o(cpu_resp_rvalid_o),
        .cpu_resp_rdata_o(cpu_resp_rdata_o),
        .bus_req_req_o(bus_req_req_o),
        .bus_req_we_o(bus_req_we_o),
        .bus_req_be_o(bus_req_be_o),
        .bus_req_addr_o(bus_req_addr_o),
        .bus_req_wdata_o(bus_req_wdata_o),
        .bus_resp_gnt_i(bus_resp_gnt_i),
        .bus_resp_rvalid_i(bus_resp_rvalid_i),
        .bus_resp_rdata_i(bus_resp_rdata_i),
        .outstanding_o(outstanding_o),
        .resp_err_o(resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } reqEntry_t;

    // Reference model: queued requests, count of requests sent to the bus
    // awaiting a response, and the sticky error flag.
    reqEntry_t fifoModel[$];
    int        inflightModel = 0;
    bit        errModel = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    // Values observed in the most recent applyStimulus call
    logic        obsGnt, obsRvalid, obsBusReq, obsErr;
    logic [2:0]  obsOut;
    logic [3:0]  obsBusBe;
    logic [31:0] obsBusAddr, obsBusWdata, obsRdata;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), check outputs
    // against the model, then advance the model across the rising edge.
    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic bgnt, input logic brvalid, input logic [31:0] brdata);
        bit        expGnt, expBusReq, expRvalid;
        reqEntry_t head;
        int        occupancy;
        cpu_req_req_i     = req;
        cpu_req_we_i      = we;
        cpu_req_be_i      = be;
        cpu_req_addr_i    = addr;
        cpu_req_wdata_i   = wdata;
        bus_resp_gnt_i    = bgnt;
        bus_resp_rvalid_i = brvalid;
        bus_resp_rdata_i  = brdata;
        #1;
        occupancy = fifoModel.size();
        expGnt    = req && (occupancy < DEPTH) && ((occupancy + inflightModel) < MAX_OUTSTANDING);
        expBusReq = (occupancy > 0);
        head      = expBusReq ? fifoModel[0] : '0;
        expRvalid = brvalid && (inflightModel > 0);

        obsGnt      = cpu_resp_gnt_o;
        obsRvalid   = cpu_resp_rvalid_o;
        obsRdata    = cpu_resp_rdata_o;
        obsBusReq   = bus_req_req_o;
        obsBusBe    = bus_req_be_o;
        obsBusAddr  = bus_req_addr_o;
        obsBusWdata = bus_req_wdata_o;
        obsOut      = outstanding_o;
        obsErr      = resp_err_o;

        checkOutput("gnt",       64'(cpu_resp_gnt_o),    64'(expGnt));
        checkOutput("rvalid",    64'(cpu_resp_rvalid_o), 64'(expRvalid));
        checkOutput("rdata",     64'(cpu_resp_rdata_o),  64'(brdata));
        checkOutput("bus_req",   64'(bus_req_req_o),     64'(expBusReq));
        checkOutput("bus_we",    64'(bus_req_we_o),      64'(head.we));
        checkOutput("bus_be",    64'(bus_req_be_o),      64'(head.be));
        checkOutput("bus_addr",  64'(bus_req_addr_o),    64'(head.addr));
        checkOutput("bus_wdata", 64'(bus_req_wdata_o),   64'(head.wdata));
        checkOutput("outstanding", 64'(outstanding_o),   64'(occupancy + inflightModel));
        checkOutput("resp_err",  64'(resp_err_o),        64'(errModel));

        @(posedge clk_i);
        if (brvalid && inflightModel == 0) errModel = 1'b1;
        if (expRvalid) inflightModel--;
        if (expBusReq && bgnt) begin
            void'(fifoModel.pop_front());
            inflightModel++;
        end
        if (expGnt) fifoModel.push_back('{we: we, be: be, addr: addr, wdata: wdata});
        @(negedge clk_i);
    endtask

    task automatic idleCycle(input logic bgnt, input logic brvalid);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, bgnt, brvalid, $urandom);
    endtask

    // Assert reset asynchronously, check outputs clear immediately, release at a falling edge.
    task automatic doReset();
        @(negedge clk_i);
        cpu_req_req_i     = 1'b1;
        bus_resp_rvalid_i = 1'b1;
        bus_resp_gnt_i    = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_bus_req",     64'(bus_req_req_o),     64'(0));
        checkOutput("rst_bus_addr",    64'(bus_req_addr_o),    64'(0));
        checkOutput("rst_outstanding", 64'(outstanding_o),     64'(0));
        checkOutput("rst_gnt",         64'(cpu_resp_gnt_o),    64'(0));
        checkOutput("rst_rvalid",      64'(cpu_resp_rvalid_o), 64'(0));
        checkOutput("rst_err",         64'(resp_err_o),        64'(0));
        fifoModel.delete();
        inflightModel = 0;
        errModel      = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_req_req_i     = 1'b0;
        bus_resp_rvalid_i = 1'b0;
        rst_ni = 1'b1;
    endtask

    initial begin
        // Single read with one-cycle bus grant and response
        doReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h20010024, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_gnt_c0", 64'(obsGnt), 64'(1));
        checkOutput("rd_out_c0", 64'(obsOut), 64'(0));
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rd_busreq_c1", 64'(obsBusReq), 64'(1));
        checkOutput("rd_busaddr_c1", 64'(obsBusAddr), 64'h20010024);
        checkOutput("rd_out_c1", 64'(obsOut), 64'(1));
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("rd_rvalid_c2", 64'(obsRvalid), 64'(1));
        checkOutput("rd_rdata_c2", 64'(obsRdata), 64'hDEADBEEF);
        checkOutput("rd_out_c2", 64'(obsOut), 64'(1));
        idleCycle(1'b0, 1'b0);
        checkOutput("rd_out_c3", 64'(obsOut), 64'(0));

        // Back-pressure: bus never grants, three writes
        doReset();
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h3000, 32'hA1, 1'b0, 1'b0, 32'h0);
        checkOutput("bp_gnt0", 64'(obsGnt), 64'(1));
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h3004, 32'hA2, 1'b0, 1'b0, 32'h0);
        checkOutput("bp_gnt1", 64'(obsGnt), 64'(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 4'hF, 32'h3008, 32'hA3, 1'b0, 1'b0, 32'h0);
            checkOutput("bp_gnt2", 64'(obsGnt), 64'(0));
            checkOutput("bp_out", 64'(obsOut), 64'(2));
            checkOutput("bp_addr", 64'(obsBusAddr), 64'h3000);
            checkOutput("bp_wdata", 64'(obsBusWdata), 64'hA1);
            checkOutput("bp_be", 64'(obsBusBe), 64'hF);
        end

        // Ordering with continuous bus grant
        doReset();
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h1000, 32'h11, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_gnt0", 64'(obsGnt), 64'(1));
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h1004, 32'h22, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_gnt1", 64'(obsGnt), 64'(1));
        checkOutput("ord_addr0", 64'(obsBusAddr), 64'h1000);
        idleCycle(1'b1, 1'b0);
        checkOutput("ord_addr1", 64'(obsBusAddr), 64'h1004);
        checkOutput("ord_wdata1", 64'(obsBusWdata), 64'h22);
        checkOutput("ord_out", 64'(obsOut), 64'(2));
        idleCycle(1'b1, 1'b1);
        idleCycle(1'b1, 1'b1);
        idleCycle(1'b1, 1'b0);
        checkOutput("ord_drained", 64'(obsOut), 64'(0));

        // Credit limit with immediate grants and withheld responses
        doReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h4000, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h4004, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("cr_gnt1", 64'(obsGnt), 64'(1));
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h4008, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("cr_stall2", 64'(obsGnt), 64'(0));
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h4008, 32'h0, 1'b1, 1'b1, 32'h55);
        checkOutput("cr_stall3", 64'(obsGnt), 64'(0));
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h4008, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("cr_gnt4", 64'(obsGnt), 64'(1));
        idleCycle(1'b1, 1'b1);
        checkOutput("cr_busreq5", 64'(obsBusReq), 64'(1));
        idleCycle(1'b0, 1'b0);
        checkOutput("cr_same_cycle_out", 64'(obsOut), 64'(1));

        // Spurious response
        doReset();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD);
        checkOutput("sp_rvalid", 64'(obsRvalid), 64'(0));
        checkOutput("sp_err_before", 64'(obsErr), 64'(0));
        idleCycle(1'b0, 1'b0);
        checkOutput("sp_err_rise", 64'(obsErr), 64'(1));
        idleCycle(1'b0, 1'b0);
        checkOutput("sp_err_sticky", 64'(obsErr), 64'(1));

        // Reset mid-operation with two entries queued, then immediate grant
        doReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h5004, 32'h0, 1'b0, 1'b0, 32'h0);
        doReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h6000, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_first_gnt", 64'(obsGnt), 64'(1));

        // Pre-reset in-flight request answered after reset
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        doReset();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
        checkOutput("late_rvalid", 64'(obsRvalid), 64'(0));
        idleCycle(1'b0, 1'b0);
        checkOutput("late_err", 64'(obsErr), 64'(1));

        // Randomized traffic, several rounds separated by resets
        for (int round = 0; round < 4; round++) begin
            doReset();
            for (int n = 0; n < 250; n++) begin
                logic brv;
                brv = (inflightModel > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
                applyStimulus($urandom_range(0, 99) < 60, 1'($urandom), 4'($urandom), $urandom, $urandom,
                              $urandom_range(0, 99) < 50, brv, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ext_obi_req_buffer.md
EXT_OBI_REQ_BUFFER -- requirements
Module: ext_obi_req_buffer

Decoupling stage between the external CPU data or instruction OBI master port and the system bus. It provides a request FIFO, credit-limited outstanding tracking and response return.

Interface
REQ-001 Parameter DEPTH, default 2, sets the request FIFO depth in entries; the legal range SHALL be 1..4.
REQ-002 Parameter MAX_OUTSTANDING, default 2, sets the maximum accepted-but-unanswered transactions; the legal range SHALL be DEPTH..7.
REQ-003 clk_i  input  1  is the single clock; all state SHALL be on its rising edge.
REQ-004 rst_ni  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 cpu_req_i  input  obi_req_t  is the request from the CPU: req, we, be[3:0], addr[31:0], wdata[31:0].
REQ-006 cpu_resp_o  output  obi_resp_t  is the response to the CPU: gnt, rvalid, rdata[31:0].
REQ-007 bus_req_o  output  obi_req_t  is the request to the bus.
REQ-008 bus_resp_i  input  obi_resp_t  is the response from the bus.
REQ-009 outstanding_o  output  3  carries the current credit count (FIFO entries plus in-flight transactions).
REQ-010 resp_err_o  output  1  is a sticky flag for an unexpected bus rvalid.

Function
REQ-011 cpu_resp_o.gnt SHALL be cpu_req_i.req AND FIFO not full AND outstanding_o < MAX_OUTSTANDING, using registered state only.
- There SHALL be no combinational path from bus_resp_i to cpu_resp_o.gnt.
REQ-012 A CPU handshake (req AND gnt) SHALL push {we, be, addr, wdata} into the FIFO tail on that clock edge.
REQ-013 bus_req_o.req SHALL be 1 exactly when the FIFO is non-empty.
- bus_req_o.we, be, addr and wdata SHALL be the FIFO head fields.
- When empty, bus_req_o SHALL be all zeros.
REQ-014 A bus handshake (bus_req_o.req AND bus_resp_i.gnt) SHALL pop the FIFO head and increment the in-flight counter.
REQ-015 The head SHALL remain stable while bus_req_o.req=1 and gnt=0 (OBI stability rule).
REQ-016 The FIFO SHALL have no bypass: a request pushed in cycle N appears on bus_req_o no earlier than cycle N+1.
- Minimum CPU-grant-to-bus-request latency SHALL be 1 cycle.
REQ-017 A simultaneous push and pop SHALL leave the FIFO count unchanged and preserve order.
- Read and write pointers SHALL wrap modulo DEPTH.
REQ-018 cpu_resp_o.rvalid SHALL be bus_resp_i.rvalid AND in-flight>0.
- cpu_resp_o.rdata SHALL equal bus_resp_i.rdata combinationally (0-cycle response latency).
REQ-019 An accepted rvalid SHALL decrement the in-flight counter.
- A simultaneous bus gnt and rvalid SHALL leave the in-flight counter unchanged.
REQ-020 bus_resp_i.rvalid while in-flight=0 SHALL be dropped (not forwarded to the CPU) and SHALL set resp_err_o to 1.
- resp_err_o SHALL clear only on reset.
REQ-021 outstanding_o SHALL equal FIFO count + in-flight count.
- It SHALL never exceed MAX_OUTSTANDING.
- It SHALL update on the edge following each handshake.
REQ-022 Responses SHALL return in request order; no reordering and no ID tracking.
REQ-023 Writes SHALL consume credits and receive rvalid identically to reads.

Reset
REQ-024 While rst_ni=0, all of the following SHALL be 0:
- FIFO pointers and count;
- in-flight counter;
- resp_err_o;
- bus_req_o (all fields);
- cpu_resp_o.gnt;
- cpu_resp_o.rvalid.
REQ-025 Reset asserted mid-transaction SHALL discard FIFO contents and in-flight tracking.
- A bus rvalid arriving after reset release for a pre-reset request SHALL set resp_err_o.
REQ-026 The first CPU grant after reset release SHALL be possible in the first clock cycle with rst_ni=1.

Verification
REQ-027 Single read, defaults, bus gnt and rvalid each one cycle later:
- Stimulus: CPU read at addr 0x20010024.
- Required: cpu gnt at cycle 0; bus req at cycle 1; cpu rvalid carrying rdata 0xDEADBEEF at cycle 2; outstanding_o sequence 0,1,1,0.
REQ-028 Back-pressure: bus gnt held 0, CPU issues 3 back-to-back writes.
- Required: the first 2 are granted and the third is stalled with outstanding_o=2.
- Required: bus_req_o is stable at the first write's addr, wdata and be (0xF) throughout the stall.
REQ-029 Ordering: 2 writes to 0x1000 (wdata 0x11) and 0x1004 (wdata 0x22), with bus gnt=1 continuously.
- Required: the bus observes 0x1000 then 0x1004 in order.
- Required: push and pop occur in the same cycle with no lost entries.
REQ-030 Credit limit: MAX_OUTSTANDING=2, bus grants immediately and withholds rvalid.
- Required: the third CPU request is not granted until one rvalid is returned.
- Required: a simultaneous bus gnt and rvalid keeps in-flight at 1.
REQ-031 Spurious response: bus rvalid=1 with in-flight=0.
- Required: cpu_resp_o.rvalid stays 0 and resp_err_o rises the next cycle and stays 1.
REQ-032 Reset mid-operation: assert rst_ni=0 with 2 entries queued.
- Required: bus_req_o.req=0 and outstanding_o=0 immediately (asynchronously).
- Required: after release, a new read is granted in the first cycle.
